alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational ALU between two requesters (port 0, port 1) with valid/ready handshakes on both the request and response sides. The block registers the operands that drive the ALU and captures the result one cycle later. It then holds the result until the owning requester accepts it. It sits between the requesting datapath blocks and the single ALU instance, which it drives through its alu_* ports.

## Interface
- WIDTH, 4: operand/result width; must match the ALU.
- OPW, 2: ALU opcode width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- p0_valid, p1_valid  in  1  request valid per port.
- p0_ready, p1_ready  out  1  request accepted this cycle (combinational).
- p0_inA, p0_inB, p1_inA, p1_inB  in  WIDTH  operands.
- p0_op, p1_op  in  OPW  ALU opcode.
- p0_rsp_valid, p1_rsp_valid  out  1  result valid, registered.
- p0_rsp_ready, p1_rsp_ready  in  1  requester accepts result.
- p0_ans, p1_ans  out  WIDTH  result, registered; stable while rsp_valid=1.
- alu_inA, alu_inB  out  WIDTH  registered ALU operands.
- alu_op  out  OPW  registered ALU opcode.
- alu_ans  in  WIDTH  combinational ALU result.

## Operation
- State machine: IDLE, EXEC, RESP. Registers:
  - owner (1 bit): port being served.
  - last (1 bit): port most recently completed.
- IDLE behaviour:
  - grant goes to a port with valid=1.
  - If both are valid, grant goes to the port != last (round-robin).
  - pX_ready = (state==IDLE) && grant==X. At most one ready is high; ready never depends on rsp_ready.
- Accept (IDLE, granted valid&&ready at an edge):
  - Latch inA/inB/op into alu_inA/alu_inB/alu_op.
  - owner <= granted port.
  - Go to EXEC.
- EXEC (exactly 1 cycle): at the next edge, p<owner>_ans <= alu_ans and p<owner>_rsp_valid <= 1. Go to RESP.
- RESP:
  - Hold ans/rsp_valid until p<owner>_rsp_ready=1 at an edge.
  - On that edge: rsp_valid <= 0, last <= owner, go to IDLE.
  - The other port's rsp_valid and ans are untouched.
- Requests arriving in EXEC/RESP see ready=0 and must hold valid and operands; nothing is queued.
- alu_* outputs keep their last value outside EXEC; ALU output is only sampled in EXEC.
- Arithmetic: the block never modifies data; ans is alu_ans bit-exact, WIDTH bits, no extension.
- Reset values, and behaviour on reset in any state (including mid-EXEC/RESP):
  - All outputs 0: rsp_valid, ans, alu_inA/alu_inB/alu_op, ready.
  - state=IDLE, owner=0, last=1, so port 0 wins the first tie.
  - An in-flight operation is discarded with no response.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Timing
- Request accepted at edge N → alu_* valid after N → ans/rsp_valid high after edge N+1 (2-cycle latency).
- With rsp_ready held high, the response handshake is at edge N+2. IDLE again after N+2; the next accept is possible at N+3.
- Peak throughput: one operation per 3 cycles.
- ready is combinational from valid, state and last; no combinational path from rsp_ready to any output.
- Simultaneous valid on both ports in IDLE: exactly one accepted; the loser is accepted in the next IDLE window if still valid.
- Single requester continuously valid: served back-to-back (every 3 cycles) regardless of last.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie; last is still tracked but unused for grant; port 1 can starve.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin tie-break as above.

## Test plan
Bench ALU stub: alu_ans = (alu_inA + alu_inB) mod 2^WIDTH for every op.
- Reset check: reset=1 for 3 cycles with both valids high → all outputs 0, no ready. Release → p0_ready=1 first (last=1).
- Single request: p0 inA=2, inB=3, op=2 accepted at edge N, rsp_ready=1 → p0_rsp_valid=1 with p0_ans=5 during cycle N+1..N+2 only; alu_inA=2, alu_inB=3, alu_op=2 after N.
- Tie, round-robin: both valid continuously (p0 1+1, p1 7+8) → grant order p0, p1, p0, p1; p0_ans=2, p1_ans=15 (wrap: 7+8=15, then p1 9+9 → 2).
- Backpressure: p1 request, p1_rsp_ready=0 for 5 cycles → p1_ans stable and p1_rsp_valid=1 throughout; p0_ready=0 throughout; on rsp_ready=1 one cycle later, IDLE and p0 is granted.
- Reset mid-operation: assert reset in EXEC → next cycle no rsp_valid on either port, state IDLE, pending response never appears.
- With ALU_ARB_FIXED_PRIO_EN: both valid continuously → only p0 is ever granted; p1_ready never high.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes for both ports plus the ALU link.
// The master side is the environment; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 2
);
  logic             p0_valid;
  logic             p0_ready;
  logic [WIDTH-1:0] p0_inA;
  logic [WIDTH-1:0] p0_inB;
  logic [OPW-1:0]   p0_op;
  logic             p0_rsp_valid;
  logic             p0_rsp_ready;
  logic [WIDTH-1:0] p0_ans;

  logic             p1_valid;
  logic             p1_ready;
  logic [WIDTH-1:0] p1_inA;
  logic [WIDTH-1:0] p1_inB;
  logic [OPW-1:0]   p1_op;
  logic             p1_rsp_valid;
  logic             p1_rsp_ready;
  logic [WIDTH-1:0] p1_ans;

  logic [WIDTH-1:0] alu_inA;
  logic [WIDTH-1:0] alu_inB;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_ans;

  modport master (
    output p0_valid, p0_inA, p0_inB, p0_op,
    output p0_rsp_ready,
    input  p0_ready, p0_rsp_valid, p0_ans,
    output p1_valid, p1_inA, p1_inB, p1_op,
    output p1_rsp_ready,
    input  p1_ready, p1_rsp_valid, p1_ans,
    input  alu_inA, alu_inB, alu_op,
    output alu_ans
  );

  modport slave (
    input  p0_valid, p0_inA, p0_inB, p0_op,
    input  p0_rsp_ready,
    output p0_ready, p0_rsp_valid, p0_ans,
    input  p1_valid, p1_inA, p1_inB, p1_op,
    input  p1_rsp_ready,
    output p1_ready, p1_rsp_valid, p1_ans,
    output alu_inA, alu_inB, alu_op,
    input  alu_ans
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 tie priority (default round-robin).
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 2
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   owner_q;
  logic   last_q;
  logic   tie;
  logic   grant;
  logic   idle;
  logic   acc;
  logic   own_rr;
  logic   done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie = 1'b0;
`else
  assign tie = ~last_q;
`endif

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (bus.p0_valid & bus.p1_valid):
        grant = tie;
      (bus.p1_valid & ~bus.p0_valid):
        grant = 1'b1;
      default:
        grant = 1'b0;
    endcase
  end

  // ready is held low while reset is asserted
  always_comb begin
    idle         = (state_q == IDLE) & ~reset;
    bus.p0_ready = idle & bus.p0_valid & ~grant;
    bus.p1_ready = idle & bus.p1_valid & grant;
    acc          = bus.p0_ready | bus.p1_ready;
    own_rr       = owner_q ? bus.p1_rsp_ready
                           : bus.p0_rsp_ready;
    done         = (state_q == RESP) & own_rr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (own_rr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      if (acc)  owner_q <= grant;
      if (done) last_q  <= owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_inA <= '0;
      bus.alu_inB <= '0;
      bus.alu_op  <= '0;
    end else if (acc) begin
      bus.alu_inA <= grant ? bus.p1_inA : bus.p0_inA;
      bus.alu_inB <= grant ? bus.p1_inB : bus.p0_inB;
      bus.alu_op  <= grant ? bus.p1_op  : bus.p0_op;
    end
  end

  // only the owner's response registers ever change
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.p0_rsp_valid <= 1'b0;
      bus.p1_rsp_valid <= 1'b0;
      bus.p0_ans       <= '0;
      bus.p1_ans       <= '0;
    end else if (state_q == EXEC) begin
      if (owner_q) begin
        bus.p1_rsp_valid <= 1'b1;
        bus.p1_ans       <= bus.alu_ans;
      end else begin
        bus.p0_rsp_valid <= 1'b1;
        bus.p0_ans       <= bus.alu_ans;
      end
    end else if (done) begin
      if (owner_q) bus.p1_rsp_valid <= 1'b0;
      else         bus.p0_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized traffic against a transaction-level model.
// Build with ALU_ARB_FIXED_PRIO_EN to check fixed-priority ties.
module tb_alu_arbiter;
  localparam int W = 4;
  localparam int O = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .OPW(O)) bus ();

  alu_arbiter #(.WIDTH(W), .OPW(O)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  assign bus.alu_ans = bus.alu_inA + bus.alu_inB;

  int total = 0;
  int bad   = 0;

  // stimulus state
  bit         v[2];
  bit [W-1:0] a[2];
  bit [W-1:0] b[2];
  bit [O-1:0] op[2];
  bit         rr[2];
  bit         hold[2];
  int         pv[2];
  int         prr[2];
  int         prst;
  int         rst_left;
  bit         tieops;
  bit         p1flip;

  // model state: a pending job and the responses it owes
  bit         busy;
  bit         pend;
  bit         own;
  bit         lst;
  bit [W-1:0] ma;
  bit [W-1:0] mb;
  bit [O-1:0] mop;
  bit         ev[2];
  bit [W-1:0] ea[2];
  int         p1_grants;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    if (rst_left > 0) begin
      reset = 1'b1;
      rst_left--;
    end else begin
      reset = ($urandom_range(999) < prst);
    end
    for (int p = 0; p < 2; p++) begin
      if (!hold[p]) begin
        v[p] = ($urandom_range(99) < pv[p]);
        if (tieops) begin
          if (p == 0) begin
            a[p] = 4'd1; b[p] = 4'd1;
          end else begin
            a[p] = p1flip ? 4'd9 : 4'd7;
            b[p] = p1flip ? 4'd9 : 4'd8;
          end
          op[p] = O'($urandom_range(3));
        end else begin
          a[p]  = W'($urandom);
          b[p]  = W'($urandom);
          op[p] = O'($urandom);
        end
      end
      rr[p] = ($urandom_range(99) < prr[p]);
    end
    bus.p0_valid = v[0]; bus.p0_inA = a[0];
    bus.p0_inB = b[0];   bus.p0_op = op[0];
    bus.p1_valid = v[1]; bus.p1_inA = a[1];
    bus.p1_inB = b[1];   bus.p1_op = op[1];
    bus.p0_rsp_ready = rr[0];
    bus.p1_rsp_ready = rr[1];
  endtask

  task automatic check_and_step();
    bit tie, g, r0, r1, p;
`ifdef ALU_ARB_FIXED_PRIO_EN
    tie = 1'b0;
`else
    tie = !lst;
`endif
    g  = (v[0] && v[1]) ? tie : v[1];
    r0 = !reset && !busy && v[0] && !g;
    r1 = !reset && !busy && v[1] && g;
    chk("p0_ready", int'(bus.p0_ready), int'(r0));
    chk("p1_ready", int'(bus.p1_ready), int'(r1));
    chk("p0_rsp_valid", int'(bus.p0_rsp_valid), int'(ev[0]));
    chk("p1_rsp_valid", int'(bus.p1_rsp_valid), int'(ev[1]));
    chk("p0_ans", int'(bus.p0_ans), int'(ea[0]));
    chk("p1_ans", int'(bus.p1_ans), int'(ea[1]));
    chk("alu_inA", int'(bus.alu_inA), int'(ma));
    chk("alu_inB", int'(bus.alu_inB), int'(mb));
    chk("alu_op", int'(bus.alu_op), int'(mop));
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    if (reset) begin
      busy = 0; pend = 0; own = 0; lst = 1;
      ev[0] = 0; ev[1] = 0; ea[0] = '0; ea[1] = '0;
      ma = '0; mb = '0; mop = '0;
    end else begin
      hold[0] = v[0] && !r0;
      hold[1] = v[1] && !r1;
      if (!busy) begin
        if (r0 || r1) begin
          p = r1;
          busy = 1; pend = 1; own = p;
          ma = a[p]; mb = b[p]; mop = op[p];
          if (p) begin
            p1_grants++;
            p1flip = !p1flip;
          end
        end
      end else if (pend) begin
        pend = 0;
        ev[own] = 1'b1;
        ea[own] = ma + mb;
      end else if (rr[own]) begin
        ev[own] = 1'b0;
        lst = own;
        busy = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_and_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    busy = 0; pend = 0; own = 0; lst = 1;
    ev[0] = 0; ev[1] = 0; ea[0] = '0; ea[1] = '0;
    ma = '0; mb = '0; mop = '0;
    hold[0] = 0; hold[1] = 0;
    p1_grants = 0; p1flip = 0;
    prst = 0;
    tieops = 1'b1;
    pv[0] = 100; pv[1] = 100;
    prr[0] = 100; prr[1] = 100;
    rst_left = 3;
    drive();
    // reset held with both valid, then a continuous tie
    run(24);
    // p1 alone, held response, then p0 joins
    tieops = 1'b0;
    pv[0] = 0; pv[1] = 100;
    prr[0] = 100; prr[1] = 0;
    run(8);
    prr[1] = 100;
    pv[0] = 100;
    run(12);
    // mixed random traffic with occasional resets
    pv[0] = 50; pv[1] = 50;
    prr[0] = 60; prr[1] = 60;
    prst = 10;
    run(2000);
    // frequent resets to land in every state
    prst = 150;
    run(400);
    // saturated ties with slow consumers
    prst = 0;
    pv[0] = 100; pv[1] = 100;
    prr[0] = 40; prr[1] = 40;
    run(300);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("p1_starved", p1_grants, 0);
`else
    chk("p1_served", int'(p1_grants > 0), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
